// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the pipeline write-back stage, the debug loader and
// the register-file write arbiter.
interface regfile_write_arbiter_if;
    logic        wbRegWrite;
    logic [4:0]  wbRegister;
    logic [31:0] wbData;
    logic        wbReady;
    logic        dbgReq;
    logic [4:0]  dbgRegister;
    logic [31:0] dbgData;
    logic        dbgAck;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        initDone;

    modport master (
        output wbRegWrite, wbRegister, wbData, dbgReq, dbgRegister, dbgData,
        input  wbReady, dbgAck, regWrite, writeRegister, writeData, initDone
    );

    modport slave (
        input  wbRegWrite, wbRegister, wbData, dbgReq, dbgRegister, dbgData,
        output wbReady, dbgAck, regWrite, writeRegister, writeData, initDone
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: zero-fills all 32 registers after reset, then
// merges pipeline write-back and debug writes with a starvation guard for debug.
module regfile_write_arbiter #(
    parameter int INIT_ENABLE  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;

    state_t         state_r;
    state_t         state_next_s;
    logic [4:0]     idx_r;
    logic [4:0]     idx_next_s;
    logic [SW-1:0]  starve_r;
    logic [SW-1:0]  starve_next_s;
    logic           reg_write_r;
    logic [4:0]     write_register_r;
    logic [31:0]    write_data_r;
    logic           dbg_ack_r;
    logic           init_done_r;

    logic           wb_ready_s;
    logic           grant_s;
    logic           wb_xfer_s;
    logic           at_limit_s;
    logic           reg_write_next_s;
    logic [4:0]     write_register_next_s;
    logic [31:0]    write_data_next_s;
    logic           dbg_ack_next_s;

    assign at_limit_s = (starve_r >= LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: INIT leaves once the index-31 write is issued
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (idx_r == 5'd31) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = RESET_STATE;
        endcase
    end

    // Output logic: arbitration decision and next values of the registered outputs
    always_comb begin
        wb_ready_s            = 1'b0;
        grant_s               = 1'b0;
        wb_xfer_s             = 1'b0;
        reg_write_next_s      = 1'b0;
        write_register_next_s = write_register_r;
        write_data_next_s     = write_data_r;
        dbg_ack_next_s        = 1'b0;
        idx_next_s            = idx_r;
        starve_next_s         = starve_r;
        case (state_r)
            ST_INIT: begin
                reg_write_next_s      = 1'b1;
                write_register_next_s = idx_r;
                write_data_next_s     = 32'h0000_0000;
                idx_next_s            = idx_r + 5'd1;
                starve_next_s         = {SW{1'b0}};
            end
            ST_RUN: begin
                // A starved debug request blocks the pipeline for exactly one cycle
                wb_ready_s = !(bus.dbgReq && at_limit_s && !dbg_ack_r);
                grant_s    = bus.dbgReq && !dbg_ack_r && (!bus.wbRegWrite || at_limit_s);
                wb_xfer_s  = bus.wbRegWrite && wb_ready_s && !grant_s;
                if (grant_s) begin
                    reg_write_next_s      = (bus.dbgRegister != 5'd0);
                    write_register_next_s = bus.dbgRegister;
                    write_data_next_s     = bus.dbgData;
                    dbg_ack_next_s        = 1'b1;
                end else if (wb_xfer_s) begin
                    reg_write_next_s      = (bus.wbRegister != 5'd0);
                    write_register_next_s = bus.wbRegister;
                    write_data_next_s     = bus.wbData;
                end else begin
                    reg_write_next_s      = 1'b0;
                end
                if (!bus.dbgReq || grant_s) begin
                    starve_next_s = {SW{1'b0}};
                end else if (!dbg_ack_r && !at_limit_s) begin
                    starve_next_s = starve_r + {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    starve_next_s = starve_r;
                end
            end
            default: begin
                reg_write_next_s = 1'b0;
            end
        endcase
    end

    // Registered outputs, fill index and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r            <= 5'd0;
            starve_r         <= {SW{1'b0}};
            reg_write_r      <= 1'b0;
            write_register_r <= 5'd0;
            write_data_r     <= 32'h0000_0000;
            dbg_ack_r        <= 1'b0;
            init_done_r      <= 1'b0;
        end else begin
            idx_r            <= idx_next_s;
            starve_r         <= starve_next_s;
            reg_write_r      <= reg_write_next_s;
            write_register_r <= write_register_next_s;
            write_data_r     <= write_data_next_s;
            dbg_ack_r        <= dbg_ack_next_s;
            init_done_r      <= init_done_r | (state_r == ST_RUN);
        end
    end

    assign bus.wbReady       = wb_ready_s && !reset;
    assign bus.dbgAck        = dbg_ack_r;
    assign bus.regWrite      = reg_write_r;
    assign bus.writeRegister = write_register_r;
    assign bus.writeData     = write_data_r;
    assign bus.initDone      = init_done_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_regfile_write_arbiter;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.INIT_ENABLE(1), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model state
    bit          m_run;
    int          m_idx;
    int          m_starve;
    bit          m_ack;
    bit          m_rw;
    int          m_wreg;
    logic [31:0] m_wdata;
    bit          m_done;

    function automatic bit pred_ready();
        return !reset && m_run && !(bus.dbgReq && m_starve >= LIMIT && !m_ack);
    endfunction

    function automatic bit pred_grant();
        return !reset && m_run && bus.dbgReq && !m_ack && (!bus.wbRegWrite || m_starve >= LIMIT);
    endfunction

    // Advance one clock from negedge to negedge, updating the model
    task automatic tick();
        bit          rdy, gnt, xfer, old_ack, rst, dreq;
        int          dreg, wreg;
        logic [31:0] ddat, wdat;
        rdy = pred_ready(); gnt = pred_grant(); xfer = bus.wbRegWrite && rdy;
        old_ack = m_ack; rst = reset; dreq = bus.dbgReq;
        dreg = bus.dbgRegister; ddat = bus.dbgData; wreg = bus.wbRegister; wdat = bus.wbData;
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_idx = 0; m_starve = 0; m_ack = 1'b0;
            m_rw = 1'b0; m_wreg = 0; m_wdata = 32'h0; m_done = 1'b0;
        end else if (!m_run) begin
            m_rw = 1'b1; m_wreg = m_idx; m_wdata = 32'h0; m_ack = 1'b0;
            m_run = (m_idx == 31); m_idx = m_idx + 1; m_starve = 0;
        end else begin
            m_done = 1'b1;
            if (gnt) begin
                m_rw = (dreg != 0); m_wreg = dreg; m_wdata = ddat; m_ack = 1'b1;
            end else if (xfer) begin
                m_rw = (wreg != 0); m_wreg = wreg; m_wdata = wdat; m_ack = 1'b0;
            end else begin
                m_rw = 1'b0; m_ack = 1'b0;
            end
            if (!dreq || gnt) m_starve = 0;
            else if (!old_ack) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wbRegWrite = 1'b0; bus.wbRegister = 5'd0; bus.wbData = 32'h0;
        bus.dbgReq = 1'b0; bus.dbgRegister = 5'd0; bus.dbgData = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.wbRegWrite = 1'b1; bus.wbRegister = 5'd3; bus.dbgReq = 1'b1; bus.dbgRegister = 5'd4;
        #1;
        checks++; if (bus.wbReady !== 1'b0) begin errors++; $display("FAIL rst_wbReady got=%b exp=0", bus.wbReady); end
        tick();
        tick();
        checks++; if (bus.wbReady !== 1'b0) begin errors++; $display("FAIL rst_wbReady2 got=%b exp=0", bus.wbReady); end
        checks++; if (bus.regWrite !== 1'b0 || bus.dbgAck !== 1'b0 || bus.initDone !== 1'b0) begin
            errors++; $display("FAIL rst_flags got rw=%b ack=%b done=%b exp all 0", bus.regWrite, bus.dbgAck, bus.initDone); end
        checks++; if (bus.writeRegister !== 5'd0 || bus.writeData !== 32'h0) begin
            errors++; $display("FAIL rst_addr_data got %0d/%h exp 0/0", bus.writeRegister, bus.writeData); end
        idle_inputs();
    endtask

    task automatic test_zero_fill();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++; if (bus.wbReady !== 1'b0) begin errors++; $display("FAIL zf_wbReady k=%0d got=%b exp=0", k, bus.wbReady); end
            tick();
            checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'(k) || bus.writeData !== 32'h0) begin
                errors++; $display("FAIL zf_write k=%0d got rw=%b reg=%0d data=%h exp rw=1 reg=%0d data=0", k, bus.regWrite, bus.writeRegister, bus.writeData, k); end
            checks++; if (bus.initDone !== 1'b0) begin errors++; $display("FAIL zf_initDone_early k=%0d got=%b exp=0", k, bus.initDone); end
        end
        tick();
        checks++; if (bus.initDone !== 1'b1) begin errors++; $display("FAIL zf_initDone got=%b exp=1", bus.initDone); end
        checks++; if (bus.regWrite !== 1'b0 || bus.writeRegister !== 5'd31) begin
            errors++; $display("FAIL zf_after got rw=%b reg=%0d exp rw=0 reg=31", bus.regWrite, bus.writeRegister); end
    endtask

    task automatic test_wb_path();
        bus.wbRegWrite = 1'b1; bus.wbRegister = 5'd5; bus.wbData = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.wbReady !== 1'b1) begin errors++; $display("FAIL wb_ready got=%b exp=1", bus.wbReady); end
        tick();
        checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd5 || bus.writeData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_write got rw=%b reg=%0d data=%h exp 1/5/deadbeef", bus.regWrite, bus.writeRegister, bus.writeData); end
        idle_inputs();
        tick();
        checks++; if (bus.regWrite !== 1'b0 || bus.writeRegister !== 5'd5 || bus.writeData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wb_idle_hold got rw=%b reg=%0d data=%h exp 0/5/deadbeef", bus.regWrite, bus.writeRegister, bus.writeData); end
    endtask

    task automatic test_zero_protect();
        bus.wbRegWrite = 1'b1; bus.wbRegister = 5'd0; bus.wbData = 32'h0000_1234;
        #1;
        checks++; if (bus.wbReady !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", bus.wbReady); end
        tick();
        checks++; if (bus.regWrite !== 1'b0 || bus.writeRegister !== 5'd0 || bus.writeData !== 32'h0000_1234) begin
            errors++; $display("FAIL zero_write got rw=%b reg=%0d data=%h exp 0/0/1234", bus.regWrite, bus.writeRegister, bus.writeData); end
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        bus.dbgReq = 1'b1; bus.dbgRegister = 5'd9; bus.dbgData = 32'h77;
        for (int c = 1; c <= 3; c++) begin
            bus.wbRegWrite = 1'b1; bus.wbRegister = 5'(c); bus.wbData = 32'h100 + 32'(c);
            #1;
            checks++; if (bus.wbReady !== 1'b1) begin errors++; $display("FAIL starve_wb_ready c=%0d got=%b exp=1", c, bus.wbReady); end
            tick();
            checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'(c) || bus.dbgAck !== 1'b0) begin
                errors++; $display("FAIL starve_wb_win c=%0d got rw=%b reg=%0d ack=%b exp 1/%0d/0", c, bus.regWrite, bus.writeRegister, bus.dbgAck, c); end
        end
        bus.wbRegister = 5'd4; bus.wbData = 32'h104;
        #1;
        checks++; if (bus.wbReady !== 1'b0) begin errors++; $display("FAIL starve_block got=%b exp=0", bus.wbReady); end
        tick();
        checks++; if (bus.dbgAck !== 1'b1 || bus.regWrite !== 1'b1 || bus.writeRegister !== 5'd9 || bus.writeData !== 32'h77) begin
            errors++; $display("FAIL starve_grant got ack=%b rw=%b reg=%0d data=%h exp 1/1/9/77", bus.dbgAck, bus.regWrite, bus.writeRegister, bus.writeData); end
        bus.dbgReq = 1'b0;
        #1;
        checks++; if (bus.wbReady !== 1'b1) begin errors++; $display("FAIL starve_resume_ready got=%b exp=1", bus.wbReady); end
        tick();
        checks++; if (bus.dbgAck !== 1'b0 || bus.writeRegister !== 5'd4 || bus.writeData !== 32'h104) begin
            errors++; $display("FAIL starve_resume got ack=%b reg=%0d data=%h exp 0/4/104", bus.dbgAck, bus.writeRegister, bus.writeData); end
        idle_inputs();
        tick();
    endtask

    task automatic test_idle_debug();
        bus.dbgReq = 1'b1; bus.dbgRegister = 5'd12; bus.dbgData = 32'hCAFE_0012;
        tick();
        checks++; if (bus.dbgAck !== 1'b1 || bus.writeRegister !== 5'd12 || bus.writeData !== 32'hCAFE_0012) begin
            errors++; $display("FAIL idbg_ack got ack=%b reg=%0d data=%h exp 1/12/cafe0012", bus.dbgAck, bus.writeRegister, bus.writeData); end
        // Replacement request issued in the ack cycle must wait one cycle
        bus.dbgRegister = 5'd13; bus.dbgData = 32'hCAFE_0013;
        tick();
        checks++; if (bus.dbgAck !== 1'b0 || bus.regWrite !== 1'b0) begin
            errors++; $display("FAIL idbg_one_cycle got ack=%b rw=%b exp 0/0", bus.dbgAck, bus.regWrite); end
        tick();
        checks++; if (bus.dbgAck !== 1'b1 || bus.writeRegister !== 5'd13) begin
            errors++; $display("FAIL idbg_second got ack=%b reg=%0d exp 1/13", bus.dbgAck, bus.writeRegister); end
        bus.dbgReq = 1'b0;
        tick();
        checks++; if (bus.dbgAck !== 1'b0) begin errors++; $display("FAIL idbg_drop got=%b exp=0", bus.dbgAck); end
    endtask

    task automatic test_random();
        bit accepted = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (bus.dbgAck) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.dbgRegister = 5'($urandom_range(0, 31)); bus.dbgData = $urandom;
                end else begin
                    bus.dbgReq = 1'b0;
                end
            end else if (!bus.dbgReq && $urandom_range(0, 3) == 0) begin
                bus.dbgReq = 1'b1; bus.dbgRegister = 5'($urandom_range(0, 31)); bus.dbgData = $urandom;
            end
            if (!bus.wbRegWrite || accepted) begin
                bus.wbRegWrite = ($urandom_range(0, 9) < 8);
                bus.wbRegister = 5'($urandom_range(0, 31)); bus.wbData = $urandom;
            end
            #1;
            checks++; if (bus.wbReady !== pred_ready()) begin
                errors++; $display("FAIL rnd_wbReady n=%0d got=%b exp=%b", n, bus.wbReady, pred_ready()); end
            accepted = bus.wbRegWrite && bus.wbReady;
            tick();
            checks++; if (bus.regWrite !== m_rw || bus.dbgAck !== m_ack) begin
                errors++; $display("FAIL rnd_ctrl n=%0d got rw=%b ack=%b exp rw=%b ack=%b", n, bus.regWrite, bus.dbgAck, m_rw, m_ack); end
            checks++; if (bus.writeRegister !== 5'(m_wreg) || bus.writeData !== m_wdata) begin
                errors++; $display("FAIL rnd_data n=%0d got reg=%0d data=%h exp reg=%0d data=%h", n, bus.writeRegister, bus.writeData, m_wreg, m_wdata); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mid_init_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (bus.writeRegister !== 5'd9 || bus.initDone !== 1'b0) begin
            errors++; $display("FAIL mid_pre got reg=%0d done=%b exp 9/0", bus.writeRegister, bus.initDone); end
        reset = 1'b1;
        #1;
        checks++; if (bus.wbReady !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", bus.wbReady); end
        tick();
        checks++; if (bus.regWrite !== 1'b0 || bus.writeRegister !== 5'd0) begin
            errors++; $display("FAIL mid_nowrite got rw=%b reg=%0d exp 0/0", bus.regWrite, bus.writeRegister); end
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            checks++; if (bus.regWrite !== 1'b1 || bus.writeRegister !== 5'(k) || bus.initDone !== 1'b0) begin
                errors++; $display("FAIL mid_refill k=%0d got rw=%b reg=%0d done=%b exp 1/%0d/0", k, bus.regWrite, bus.writeRegister, bus.initDone, k); end
        end
        tick();
        checks++; if (bus.initDone !== 1'b1) begin errors++; $display("FAIL mid_initDone got=%b exp=1", bus.initDone); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_zero_fill();
        test_wb_path();
        test_zero_protect();
        test_starvation();
        test_idle_debug();
        test_random();
        test_mid_init_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter INIT_ENABLE, default 1: 1 = run the zero-fill sequence after reset; 0 = go straight to RUN.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3: number of consecutive refused debug cycles before debug gets forced priority.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port wbRegWrite, input, 1 bit: pipeline write-back valid.
REQ-007 SHALL have port wbRegister, input, 5 bits: pipeline destination register.
REQ-008 SHALL have port wbData, input, 32 bits: pipeline write data.
REQ-009 SHALL have port wbReady, output, 1 bit: combinational ready; a transfer occurs when wbRegWrite && wbReady.
REQ-010 SHALL have port dbgReq, input, 1 bit: debug/loader write request, level, held until dbgAck.
REQ-011 SHALL have port dbgRegister, input, 5 bits: debug destination register.
REQ-012 SHALL have port dbgData, input, 32 bits: debug write data.
REQ-013 SHALL have port dbgAck, output, 1 bit: registered one-cycle grant pulse.
REQ-014 SHALL have port regWrite, output, 1 bit: registered write enable to the register file.
REQ-015 SHALL have port writeRegister, output, 5 bits: registered write address.
REQ-016 SHALL have port writeData, output, 32 bits: registered write data.
REQ-017 SHALL have port initDone, output, 1 bit: high once the zero-fill sequence has completed.

Function
REQ-018 SHALL implement FSM states INIT and RUN.
- After reset: state = INIT if INIT_ENABLE = 1, otherwise RUN.
- INIT -> RUN after the index-31 write is issued.
- RUN has no exit except reset.
REQ-019 SHALL, in INIT, present one write per cycle on the registered outputs:
- regWrite = 1, writeRegister = idx, writeData = 0.
- idx counts 0..31, one step per cycle; the first write appears in the first cycle after reset deasserts.
REQ-020 SHALL, in INIT, hold wbReady = 0 and dbgAck = 0 and grant nothing.
REQ-021 SHALL set initDone = 1 in the cycle after the idx-31 write, or on the first post-reset cycle when INIT_ENABLE = 0; initDone stays 1 until reset.
REQ-022 SHALL drive wbReady = (state == RUN) && !(dbgReq && starve >= STARVE_LIMIT && !dbgAck).
REQ-023 SHALL grant debug in a RUN cycle when dbgReq && !dbgAck && (!wbRegWrite || starve >= STARVE_LIMIT).
REQ-024 SHALL give an accepted WB transfer priority over debug in all other cases.
REQ-025 SHALL have 1-cycle latency: a transfer or grant in cycle N produces, in cycle N+1:
- writeRegister and writeData equal to the source address and data;
- regWrite = 1 if the address is non-zero;
- dbgAck = 1 in N+1 for a debug grant.
REQ-026 SHALL suppress writes to register 0: the transfer or grant is still accepted/acked, but regWrite = 0; writeRegister and writeData still update.
REQ-027 SHALL, in a RUN cycle with no transfer and no grant, set regWrite = 0 and hold writeRegister and writeData.
REQ-028 SHALL maintain counter starve:
- +1 in each RUN cycle where dbgReq && !dbgAck and no grant occurs;
- saturates at STARVE_LIMIT;
- cleared on a grant and when dbgReq = 0.
REQ-029 SHALL never grant both sources in the same cycle; the requester drops or replaces dbgReq in the cycle it sees dbgAck, and no re-grant occurs while dbgAck = 1.
REQ-030 SHALL, with a WB transfer and a forced debug grant in the same cycle, grant debug only; wbReady = 0 that cycle and the WB stays pending.

Reset
REQ-031 SHALL, while reset = 1 at posedge:
- set regWrite = 0, writeRegister = 0, writeData = 0, dbgAck = 0, initDone = 0;
- set idx = 0, starve = 0;
- set state = INIT if INIT_ENABLE = 1, else RUN.
REQ-032 SHALL drive wbReady = 0 while reset = 1.
REQ-033 SHALL, on reset asserted mid-INIT or mid-RUN, abandon any pending operation with no write on the following cycle, and restart the sequence from idx 0.

Verification
REQ-034 SHALL verify zero-fill: reset for 2 cycles, then release -> regWrite = 1 for exactly 32 cycles, writeRegister 0..31, writeData = 0; initDone = 1 on the next cycle; wbReady = 0 throughout.
REQ-035 SHALL verify WB path: RUN, wbRegWrite = 1, wbRegister = 5, wbData = 0xDEADBEEF -> wbReady = 1; next cycle regWrite = 1, writeRegister = 5, writeData = 0xDEADBEEF.
REQ-036 SHALL verify $zero protection: WB to register 0 with data 0x1234 -> transfer accepted; next cycle regWrite = 0, writeRegister = 0.
REQ-037 SHALL verify starvation guard: wbRegWrite = 1 every cycle with dbgReq = 1, dbgRegister = 9, dbgData = 0x77, STARVE_LIMIT = 3 -> WB wins for 3 cycles; 4th cycle wbReady = 0; next cycle dbgAck = 1, writeRegister = 9, writeData = 0x77; WB resumes after.
REQ-038 SHALL verify idle debug: dbgReq = 1 with wbRegWrite = 0 -> dbgAck = 1 next cycle, for exactly one cycle.
REQ-039 SHALL verify mid-INIT reset: reset asserted at idx = 10 -> no write the next cycle; after release the sequence restarts at writeRegister = 0; initDone = 0 until the idx-31 write completes.
